// File: rtl/mc_maindec.sv
// Multicycle MIPS-style main decoder: control FSM, Moore control outputs gated
// by the memory handshake, and a retired-instruction counter.
module mc_maindec #(
  parameter int EXT_OPS = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             irwrite,
  output logic             memwrite,
  output logic             regwrite,
  output logic             iord,
  output logic             alusrca,
  output logic             regdst,
  output logic             memtoreg,
  output logic             branch,
  output logic             branch_ne,
  output logic             zeroext,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [1:0]       aluop,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR  = 4'd2,  MEMRD   = 4'd3,
    MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6,  RTYPEWB = 4'd7,
    BEQEX   = 4'd8,  ADDIEX  = 4'd9,  ADDIWB  = 4'd10, JEX     = 4'd11,
    BNEEX   = 4'd12, ORIEX   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam bit         EXT_EN   = (EXT_OPS != 0);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg;
  logic             op_legal;

  always_comb begin
    op_legal   = 1'b1;
    state_next = state_reg;
    case (state_reg)
      FETCH:   if (mem_ready) state_next = DECODE;
      DECODE: begin
        case (op)
          OP_RTYPE:     state_next = RTYPEEX;
          OP_LW, OP_SW: state_next = MEMADR;
          OP_BEQ:       state_next = BEQEX;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JEX;
          OP_BNE:       state_next = EXT_EN ? BNEEX : FETCH;
          OP_ORI:       state_next = EXT_EN ? ORIEX : FETCH;
          default:      state_next = FETCH;
        endcase
        if (!EXT_EN && (op == OP_BNE || op == OP_ORI)) op_legal = 1'b0;
        if (state_next == FETCH) op_legal = 1'b0;
      end
      MEMADR:  state_next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (mem_ready) state_next = MEMWB;
      MEMWR:   if (mem_ready) state_next = FETCH;
      RTYPEEX: state_next = RTYPEWB;
      ADDIEX:  state_next = ADDIWB;
      ORIEX:   state_next = ADDIWB;
      MEMWB, RTYPEWB, ADDIWB, BEQEX, BNEEX, JEX: state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FETCH;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (instr_done) count_reg <= count_reg + CNT_W'(1);
    end
  end

  always_comb begin
    pcwrite = 1'b0; irwrite = 1'b0; memwrite = 1'b0; regwrite = 1'b0;
    iord = 1'b0; alusrca = 1'b0; regdst = 1'b0; memtoreg = 1'b0;
    branch = 1'b0; branch_ne = 1'b0; zeroext = 1'b0;
    alusrcb = 2'b00; pcsrc = 2'b00; aluop = 2'b00;
    instr_done = 1'b0; illegal_op = 1'b0;
    case (state_reg)
      FETCH:   begin alusrcb = 2'b01; irwrite = mem_ready; pcwrite = mem_ready; end
      DECODE:  begin alusrcb = 2'b11; illegal_op = ~op_legal; end
      MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      MEMRD:   iord = 1'b1;
      MEMWB:   begin memtoreg = 1'b1; regwrite = 1'b1; instr_done = 1'b1; end
      MEMWR:   begin iord = 1'b1; memwrite = 1'b1; instr_done = mem_ready; end
      RTYPEEX: begin alusrca = 1'b1; aluop = 2'b10; end
      RTYPEWB: begin regdst = 1'b1; regwrite = 1'b1; instr_done = 1'b1; end
      BEQEX:   begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch = 1'b1; instr_done = 1'b1; end
      BNEEX:   begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch_ne = 1'b1; instr_done = 1'b1; end
      ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      ORIEX:   begin alusrca = 1'b1; alusrcb = 2'b10; aluop = 2'b11; zeroext = 1'b1; end
      ADDIWB:  begin regwrite = 1'b1; instr_done = 1'b1; end
      JEX:     begin pcsrc = 2'b10; pcwrite = 1'b1; instr_done = 1'b1; end
      default: ;
    endcase
    // Reset masks every side-effecting strobe, whatever state is still held.
    if (reset) begin
      pcwrite = 1'b0; irwrite = 1'b0; memwrite = 1'b0; regwrite = 1'b0;
      branch = 1'b0; branch_ne = 1'b0; instr_done = 1'b0; illegal_op = 1'b0;
    end
  end

  assign state       = state_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_mc_maindec.sv
// Scoreboard bench for mc_maindec: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares state, control strobes and counter.
module tb_mc_maindec;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] ORI = 6'b001101, JMP = 6'b000010, BAD = 6'b111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut a: EXT_OPS=1, CNT_W=32
  logic        rst_a, mr_a;
  logic [5:0]  op_a;
  logic        pw_a, iw_a, mw_a, rw_a, id_a, sa_a, rd_a, mtr_a, br_a, bne_a, ze_a, dn_a, il_a;
  logic [1:0]  sb_a, ps_a, ao_a;
  logic [3:0]  st_a;
  logic [31:0] cnt_a;
  // dut b: EXT_OPS=0, CNT_W=4
  logic        rst_b, mr_b;
  logic [5:0]  op_b;
  logic        pw_b, iw_b, mw_b, rw_b, id_b, sa_b, rd_b, mtr_b, br_b, bne_b, ze_b, dn_b, il_b;
  logic [1:0]  sb_b, ps_b, ao_b;
  logic [3:0]  st_b;
  logic [3:0]  cnt_b;

  mc_maindec #(.EXT_OPS(1), .CNT_W(32)) dut_a (
    .clk(clk), .reset(rst_a), .op(op_a), .mem_ready(mr_a),
    .pcwrite(pw_a), .irwrite(iw_a), .memwrite(mw_a), .regwrite(rw_a), .iord(id_a),
    .alusrca(sa_a), .regdst(rd_a), .memtoreg(mtr_a), .branch(br_a), .branch_ne(bne_a),
    .zeroext(ze_a), .alusrcb(sb_a), .pcsrc(ps_a), .aluop(ao_a), .state(st_a),
    .instr_done(dn_a), .illegal_op(il_a), .instr_count(cnt_a));

  mc_maindec #(.EXT_OPS(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(rst_b), .op(op_b), .mem_ready(mr_b),
    .pcwrite(pw_b), .irwrite(iw_b), .memwrite(mw_b), .regwrite(rw_b), .iord(id_b),
    .alusrca(sa_b), .regdst(rd_b), .memtoreg(mtr_b), .branch(br_b), .branch_ne(bne_b),
    .zeroext(ze_b), .alusrcb(sb_b), .pcsrc(ps_b), .aluop(ao_b), .state(st_b),
    .instr_done(dn_b), .illegal_op(il_b), .instr_count(cnt_b));

  // {pcwrite,irwrite,memwrite,regwrite,iord,alusrca,regdst,memtoreg,branch,branch_ne,zeroext,alusrcb,pcsrc,aluop,instr_done,illegal_op}
  logic [18:0] ctrl_a, ctrl_b;
  assign ctrl_a = {pw_a, iw_a, mw_a, rw_a, id_a, sa_a, rd_a, mtr_a, br_a, bne_a, ze_a, sb_a, ps_a, ao_a, dn_a, il_a};
  assign ctrl_b = {pw_b, iw_b, mw_b, rw_b, id_b, sa_b, rd_b, mtr_b, br_b, bne_b, ze_b, sb_b, ps_b, ao_b, dn_b, il_b};

  typedef struct {
    bit          w;
    int          idx;
    logic [3:0]  st;
    logic [18:0] ctrl;
    logic [31:0] cnt;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;
  int n_push = 0;

  // Expected control word for a state, straight from the state table.
  function automatic logic [18:0] exp_ctrl(input logic [3:0] st, input bit mr, input bit rst, input bit ill);
    logic pw, iw, mw, rw, id, sa, rd, mtr, br, bn, ze, dn, il;
    logic [1:0] sbv, ps, ao;
    {pw, iw, mw, rw, id, sa, rd, mtr, br, bn, ze, dn} = '0;
    sbv = 2'b00; ps = 2'b00; ao = 2'b00; il = ill;
    case (st)
      4'd0:  begin sbv = 2'b01; iw = mr; pw = mr; end
      4'd1:  sbv = 2'b11;
      4'd2:  begin sa = 1; sbv = 2'b10; end
      4'd3:  id = 1;
      4'd4:  begin mtr = 1; rw = 1; dn = 1; end
      4'd5:  begin id = 1; mw = 1; dn = mr; end
      4'd6:  begin sa = 1; ao = 2'b10; end
      4'd7:  begin rd = 1; rw = 1; dn = 1; end
      4'd8:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; dn = 1; end
      4'd9:  begin sa = 1; sbv = 2'b10; end
      4'd10: begin rw = 1; dn = 1; end
      4'd11: begin ps = 2'b10; pw = 1; dn = 1; end
      4'd12: begin sa = 1; ao = 2'b01; ps = 2'b01; bn = 1; dn = 1; end
      4'd13: begin sa = 1; sbv = 2'b10; ao = 2'b11; ze = 1; end
      default: ;
    endcase
    if (rst) {pw, iw, mw, rw, br, bn, dn, il} = '0;
    return {pw, iw, mw, rw, id, sa, rd, mtr, br, bn, ze, sbv, ps, ao, dn, il};
  endfunction

  // Drive one cycle of inputs, record what the DUT must show this cycle, advance.
  task automatic step(input bit w, input bit rst, input logic [5:0] o, input bit mr,
                      input logic [3:0] st, input logic [31:0] cnt, input bit ill);
    exp_t e;
    if (w) begin rst_b = rst; op_b = o; mr_b = mr; end
    else   begin rst_a = rst; op_a = o; mr_a = mr; end
    e.w = w; e.idx = n_push; e.st = st; e.cnt = cnt;
    e.ctrl = exp_ctrl(st, mr, rst, ill);
    sb.push_back(e);
    n_push++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [3:0]  ast;
      logic [18:0] actl;
      logic [31:0] acnt;
      e = sb.pop_front();
      ast  = e.w ? st_b : st_a;
      actl = e.w ? ctrl_b : ctrl_a;
      acnt = e.w ? {28'd0, cnt_b} : cnt_a;
      n_vec++;
      if (ast !== e.st) begin
        n_err++;
        $display("FAIL state dut%0d vec%0d: got %0d want %0d", e.w, e.idx, ast, e.st);
      end
      if (actl !== e.ctrl) begin
        n_err++;
        $display("FAIL ctrl dut%0d vec%0d st%0d: got %b want %b", e.w, e.idx, e.st, actl, e.ctrl);
      end
      if (acnt !== e.cnt) begin
        n_err++;
        $display("FAIL count dut%0d vec%0d: got %0d want %0d", e.w, e.idx, acnt, e.cnt);
      end
      $display("vec %0d dut%0d state=%0d ctrl=%b count=%0d", e.idx, e.w, ast, actl, acnt);
    end
  end

  initial begin
    rst_a = 1'b1; op_a = RT; mr_a = 1'b1;
    rst_b = 1'b1; op_b = RT; mr_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // reset state and reset priority over mem_ready/op
    step(0, 1, LW, 1, 0, 0, 0);
    step(0, 1, BAD, 1, 0, 0, 0);
    // lw, no wait: 0,1,2,3,4
    step(0, 0, LW, 1, 0, 0, 0); step(0, 0, LW, 1, 1, 0, 0); step(0, 0, LW, 1, 2, 0, 0);
    step(0, 0, LW, 1, 3, 0, 0); step(0, 0, LW, 1, 4, 0, 0);
    // sw with two wait cycles in MEMWR
    step(0, 0, SW, 1, 0, 1, 0); step(0, 0, SW, 1, 1, 1, 0); step(0, 0, SW, 1, 2, 1, 0);
    step(0, 0, SW, 0, 5, 1, 0); step(0, 0, SW, 0, 5, 1, 0); step(0, 0, SW, 1, 5, 1, 0);
    // fetch stall then R-type
    step(0, 0, RT, 0, 0, 2, 0); step(0, 0, RT, 0, 0, 2, 0); step(0, 0, RT, 0, 0, 2, 0);
    step(0, 0, RT, 1, 0, 2, 0); step(0, 0, RT, 1, 1, 2, 0); step(0, 0, RT, 1, 6, 2, 0);
    step(0, 0, RT, 1, 7, 2, 0);
    // addi, ori
    step(0, 0, ADDI, 1, 0, 3, 0); step(0, 0, ADDI, 1, 1, 3, 0); step(0, 0, ADDI, 1, 9, 3, 0);
    step(0, 0, ADDI, 1, 10, 3, 0);
    step(0, 0, ORI, 1, 0, 4, 0); step(0, 0, ORI, 1, 1, 4, 0); step(0, 0, ORI, 1, 13, 4, 0);
    step(0, 0, ORI, 1, 10, 4, 0);
    // beq, bne, j
    step(0, 0, BEQ, 1, 0, 5, 0); step(0, 0, BEQ, 1, 1, 5, 0); step(0, 0, BEQ, 1, 8, 5, 0);
    step(0, 0, BNE, 1, 0, 6, 0); step(0, 0, BNE, 1, 1, 6, 0); step(0, 0, BNE, 1, 12, 6, 0);
    step(0, 0, JMP, 1, 0, 7, 0); step(0, 0, JMP, 1, 1, 7, 0); step(0, 0, JMP, 1, 11, 7, 0);
    // illegal opcode: pulse in DECODE, back to FETCH, not counted
    step(0, 0, BAD, 1, 0, 8, 0); step(0, 0, BAD, 1, 1, 8, 1);
    // lw with one read wait
    step(0, 0, LW, 1, 0, 8, 0); step(0, 0, LW, 1, 1, 8, 0); step(0, 0, LW, 1, 2, 8, 0);
    step(0, 0, LW, 0, 3, 8, 0); step(0, 0, LW, 1, 3, 8, 0); step(0, 0, LW, 1, 4, 8, 0);
    // reset in RTYPEEX
    step(0, 0, RT, 1, 0, 9, 0); step(0, 0, RT, 1, 1, 9, 0); step(0, 1, RT, 1, 6, 9, 0);
    // reset during a MEMWR wait
    step(0, 0, SW, 1, 0, 0, 0); step(0, 0, SW, 1, 1, 0, 0); step(0, 0, SW, 1, 2, 0, 0);
    step(0, 1, SW, 0, 5, 0, 0);
    step(0, 0, SW, 0, 0, 0, 0);
    rst_a = 1'b1;

    // dut b: bne/ori illegal without extended ops
    step(1, 1, BNE, 1, 0, 0, 0);
    step(1, 0, BNE, 1, 0, 0, 0); step(1, 0, BNE, 1, 1, 0, 1);
    step(1, 0, ORI, 1, 0, 0, 0); step(1, 0, ORI, 1, 1, 0, 1);
    // 17 jumps on a 4-bit counter
    for (int k = 0; k < 17; k++) begin
      step(1, 0, JMP, 1, 0, 32'(k % 16), 0);
      step(1, 0, JMP, 1, 1, 32'(k % 16), 0);
      step(1, 0, JMP, 1, 11, 32'(k % 16), 0);
    end
    step(1, 0, JMP, 1, 0, 1, 0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mc_maindec.md
MC_MAINDEC -- requirements
Module: mc_maindec

Interface
REQ-001 Parameter: EXT_OPS, default 1, meaning 1 enables bne/ori decode and 0 treats them as illegal.
REQ-002 Parameter: CNT_W, default 32, meaning width of the retired-instruction counter.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: op  input  6  opcode from the instruction register, stable from DECODE until the instruction retires.
REQ-006 Port: mem_ready  input  1  memory handshake; 1 means the current memory access completes this cycle.
REQ-007 Ports, outputs, 1 bit each: pcwrite, irwrite, memwrite, regwrite, iord, alusrca, regdst, memtoreg, branch, branch_ne, zeroext.
REQ-008 Ports, outputs, 2 bits each: alusrcb, pcsrc, aluop (00 add, 01 sub, 10 funct, 11 or).
REQ-009 Ports, outputs: state (4 bits, current FSM state code); instr_done (1 bit, retire pulse); illegal_op (1 bit, pulse); instr_count (CNT_W bits, retired-instruction count).

Function
REQ-010 The FSM SHALL have these states and codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, BNEEX=12, ORIEX=13.
REQ-011 Outputs SHALL be Moore-decoded from state, except for mem_ready gating; unlisted outputs are 0.
REQ-012 FETCH: alusrcb=01, irwrite=mem_ready, pcwrite=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-013 DECODE: alusrcb=11. Next state by op: 000000->RTYPEEX, 100011/101011->MEMADR, 000100->BEQEX, 001000->ADDIEX, 000010->JEX. With EXT_OPS=1: 000101->BNEEX and 001101->ORIEX.
REQ-014 Any other op in DECODE SHALL assert illegal_op for that cycle and return to FETCH. With EXT_OPS=0, ops 000101 and 001101 are illegal.
REQ-015 MEMADR: alusrca=1, alusrcb=10. Next state is MEMRD if op=100011, else MEMWR.
REQ-016 MEMRD: iord=1. Hold while mem_ready=0; go to MEMWB when mem_ready=1.
REQ-017 MEMWB: memtoreg=1, regwrite=1; go to FETCH.
REQ-018 MEMWR: iord=1, memwrite=1 every cycle in this state. Hold while mem_ready=0; go to FETCH when mem_ready=1.
REQ-019 RTYPEEX: alusrca=1, aluop=10; go to RTYPEWB.
REQ-020 RTYPEWB: regdst=1, regwrite=1; go to FETCH.
REQ-021 BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1; go to FETCH.
REQ-022 BNEEX: same outputs as BEQEX but with branch_ne=1 and branch=0; go to FETCH.
REQ-023 ADDIEX: alusrca=1, alusrcb=10; go to ADDIWB.
REQ-024 ORIEX: alusrca=1, alusrcb=10, aluop=11, zeroext=1; go to ADDIWB.
REQ-025 ADDIWB: regwrite=1; go to FETCH.
REQ-026 JEX: pcsrc=10, pcwrite=1; go to FETCH.
REQ-027 instr_done SHALL be asserted for exactly one cycle per instruction in:
- MEMWB, RTYPEWB, ADDIWB, BEQEX, BNEEX, JEX;
- MEMWR only in the cycle where mem_ready=1.
REQ-028 instr_count SHALL increment by 1 on each clock edge where instr_done=1, wrapping from 2^CNT_W-1 to 0. Illegal ops are not counted.
REQ-029 Latency in cycles from FETCH entry, with mem_ready held at 1: lw 5, sw 4, R-type 4, addi/ori 4, beq/bne 3, j 3.
REQ-030 Memory wait cycles SHALL add exactly one cycle each, with no other change to the control sequence.

Reset
REQ-031 On a clock edge with reset=1, state SHALL become FETCH and instr_count SHALL become 0, regardless of the current state. This includes reset mid-instruction or during a memory wait.
REQ-032 While reset=1, pcwrite, irwrite, memwrite, regwrite, branch, branch_ne, instr_done and illegal_op SHALL be 0.
REQ-033 After reset is released, the FSM SHALL begin in FETCH with FETCH output values.
REQ-034 reset SHALL take priority over mem_ready and op.

Verification
REQ-035 lw: reset, then op=100011, mem_ready=1 -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 in state 4; instr_count=1.
REQ-036 sw with wait: op=101011, mem_ready=0 for 2 cycles in MEMWR -> state 5 held 3 cycles; memwrite=1 in all 3; instr_done only in the last; instr_count=1.
REQ-037 Fetch stall: mem_ready=0 for 3 cycles after reset -> state 0 held; pcwrite=0 and irwrite=0 until mem_ready=1, then a single pcwrite pulse.
REQ-038 EXT_OPS=0 with op=000101 -> illegal_op=1 in DECODE, next state 0, instr_count unchanged. With EXT_OPS=1 -> BNEEX (12) with branch_ne=1.
REQ-039 Reset mid-op: reset=1 in RTYPEEX -> next state 0, regwrite never asserted, instr_count=0.
REQ-040 Counter wrap: CNT_W=4, run 17 j instructions (op=000010) -> instr_count=1.
